// File: rtl/sap1_controller.sv
// sap1_controller: SAP-1 control sequencer with a six-state one-hot ring counter.
// Strobes are decoded combinationally from the T-state, the opcode and the halt flag.
`default_nettype none

module sap1_controller (
    input  logic       clk,
    input  logic       clr,
    input  logic       run,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       cp,
    output logic       ep,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb,
    output logic       lo,
    output logic       hlt
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tState_e;

    localparam logic [3:0] C_OP_LDA = 4'b0000;
    localparam logic [3:0] C_OP_ADD = 4'b0001;
    localparam logic [3:0] C_OP_SUB = 4'b0010;
    localparam logic [3:0] C_OP_OUT = 4'b1110;
    localparam logic [3:0] C_OP_HLT = 4'b1111;

    tState_e r_state;
    logic    r_hlt;
    logic    w_haltNow;

    // The halting edge sets the flag and keeps the counter parked on T4.
    assign w_haltNow = (r_state == T4) && (opcode == C_OP_HLT);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= T1;
            r_hlt   <= 1'b0;
        end else begin
            if (w_haltNow) begin
                r_hlt <= 1'b1;
            end
            if (run && !r_hlt && !w_haltNow) begin
                case (r_state)
                    T1:      r_state <= T2;
                    T2:      r_state <= T3;
                    T3:      r_state <= T4;
                    T4:      r_state <= T5;
                    T5:      r_state <= T6;
                    T6:      r_state <= T1;
                    default: r_state <= T1;
                endcase
            end
        end
    end

    assign t_state = r_state;
    assign hlt     = r_hlt;

    always_comb begin
        cp = 1'b0; ep = 1'b0; lm = 1'b0; ce = 1'b0;
        li = 1'b0; ei = 1'b0; la = 1'b0; ea = 1'b0;
        su = 1'b0; eu = 1'b0; lb = 1'b0; lo = 1'b0;
        if (!clr && !r_hlt) begin
            case (r_state)
                T1: begin ep = 1'b1; lm = 1'b1; end
                T2: begin cp = 1'b1; end
                T3: begin ce = 1'b1; li = 1'b1; end
                T4: begin
                    if (opcode == C_OP_LDA || opcode == C_OP_ADD || opcode == C_OP_SUB) begin
                        ei = 1'b1; lm = 1'b1;
                    end else if (opcode == C_OP_OUT) begin
                        ea = 1'b1; lo = 1'b1;
                    end
                end
                T5: begin
                    if (opcode == C_OP_LDA) begin
                        ce = 1'b1; la = 1'b1;
                    end else if (opcode == C_OP_ADD || opcode == C_OP_SUB) begin
                        ce = 1'b1; lb = 1'b1;
                    end
                end
                T6: begin
                    if (opcode == C_OP_ADD || opcode == C_OP_SUB) begin
                        eu = 1'b1; la = 1'b1;
                        su = (opcode == C_OP_SUB);
                    end
                end
                default: begin end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sap1_controller.sv
// tb_sap1_controller: directed plus randomized checks of the SAP-1 sequencer
// against an instruction-level model (step index 0..5 and a halted flag).
`default_nettype none

module tb_sap1_controller;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       run = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic [5:0] t_state;
    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;

    int vectors = 0;
    int miscompares = 0;
    int mStep = 0;
    bit mHalt = 1'b0;

    sap1_controller dut (
        .clk(clk), .clr(clr), .run(run), .opcode(opcode), .t_state(t_state),
        .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei), .la(la),
        .ea(ea), .su(su), .eu(eu), .lb(lb), .lo(lo), .hlt(hlt)
    );

    always #5 clk = ~clk;

    // Micro-program table: {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo} for each step.
    function automatic logic [11:0] expStrobes(input int step, input logic [3:0] op,
                                               input bit halted, input bit inReset);
        logic [11:0] s;
        s = 12'b0;
        if (!inReset && !halted) begin
            case (step)
                0: s = 12'b0110_0000_0000;             // ep lm
                1: s = 12'b1000_0000_0000;             // cp
                2: s = 12'b0001_1000_0000;             // ce li
                3: case (op)
                       4'h0, 4'h1, 4'h2: s = 12'b0010_0100_0000;   // ei lm
                       4'hE:             s = 12'b0000_0001_0001;   // ea lo
                       default:          s = 12'b0;
                   endcase
                4: case (op)
                       4'h0:       s = 12'b0001_0010_0000;         // ce la
                       4'h1, 4'h2: s = 12'b0001_0000_0010;         // ce lb
                       default:    s = 12'b0;
                   endcase
                5: case (op)
                       4'h1:    s = 12'b0000_0010_0100;            // eu la
                       4'h2:    s = 12'b0000_0010_1100;            // eu la su
                       default: s = 12'b0;
                   endcase
                default: s = 12'b0;
            endcase
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        logic [5:0] expT;
        expT = clr ? 6'b000001 : 6'(1 << mStep);
        check({tag, ".t_state"}, 32'(t_state), 32'(expT));
        check({tag, ".hlt"}, 32'(hlt), 32'(mHalt));
        check({tag, ".strobes"}, 32'({cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo}),
              32'(expStrobes(mStep, opcode, mHalt, clr)));
        check({tag, ".busDrivers"}, 32'($countones({ep, ce, ei, ea, eu}) <= 1), 32'd1);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (!clr) begin
            if (mStep == 3 && opcode == 4'hF) mHalt = 1'b1;
            else if (run && !mHalt) mStep = (mStep + 1) % 6;
        end
        #1;
        checkAll(tag);
    endtask

    task automatic setClr(input logic v);
        clr = v;
        if (v) begin
            mStep = 0;
            mHalt = 1'b0;
        end
        #1;
        checkAll(v ? "clrOn" : "clrOff");
    endtask

    task automatic seek(input logic [3:0] op, input int target);
        opcode = op;
        run = 1'b1;
        for (int i = 0; i < 12 && mStep != target; i++) tick("seek");
        check("seek.reached", 32'(t_state), 32'(6'(1 << target)));
    endtask

    initial begin
        #2;
        setClr(1'b1);
        tick("reset");
        tick("reset");
        setClr(1'b0);
        check("release.ep", 32'(ep), 32'd1);

        opcode = 4'h0; run = 1'b1;
        repeat (6) tick("lda");
        check("lda.wrap", 32'(t_state), 32'h01);

        opcode = 4'h1;
        repeat (6) tick("add");
        opcode = 4'h2;
        repeat (6) tick("sub");

        seek(4'h1, 4);
        setClr(1'b1);
        repeat (3) tick("midClr");
        setClr(1'b0);
        tick("postClr");
        check("postClr.cp", 32'(cp), 32'd1);

        seek(4'h0, 2);
        run = 1'b0;
        repeat (4) tick("stall");
        run = 1'b1;
        tick("unstall");
        check("unstall.t4", 32'(t_state), 32'h08);

        seek(4'hF, 3);
        tick("haltEdge");
        check("haltEdge.hlt", 32'(hlt), 32'd1);
        repeat (20) tick("halted");
        setClr(1'b1);
        tick("haltClr");
        setClr(1'b0);

        opcode = 4'h5;
        repeat (6) tick("nop");
        opcode = 4'hE;
        repeat (6) tick("out");

        repeat (400) begin
            int r;
            run = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    opcode = 4'h0;
                2, 3:    opcode = 4'h1;
                4, 5:    opcode = 4'h2;
                6:       opcode = 4'hE;
                7:       opcode = 4'hF;
                default: opcode = 4'($urandom);
            endcase
            if ($urandom_range(0, 30) == 0 || (mHalt && $urandom_range(0, 7) == 0)) begin
                setClr(1'b1);
                tick("randClr");
                setClr(1'b0);
            end
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
